nrcc_bram2_server: RTL



---
 rtl/nrcc_bram2_server.sv | 125 ++++++++++++
 1 files changed

// File: rtl/nrcc_bram2_server.sv
// rtl/nrcc_bram2_server.sv - two-port BRAM server with valid/ready channels and credit-controlled response FIFOs
module nrcc_bram2_server #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MEMSIZE    = 1024,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQA_VALID,
  output logic                  REQA_READY,
  input  logic [BE_WIDTH-1:0]   REQA_WE,
  input  logic [ADDR_WIDTH-1:0] REQA_ADDR,
  input  logic [DATA_WIDTH-1:0] REQA_DATA,
  output logic                  RSPA_VALID,
  input  logic                  RSPA_READY,
  output logic [DATA_WIDTH-1:0] RSPA_DATA,
  input  logic                  REQB_VALID,
  output logic                  REQB_READY,
  input  logic [BE_WIDTH-1:0]   REQB_WE,
  input  logic [ADDR_WIDTH-1:0] REQB_ADDR,
  input  logic [DATA_WIDTH-1:0] REQB_DATA,
  output logic                  RSPB_VALID,
  input  logic                  RSPB_READY,
  output logic [DATA_WIDTH-1:0] RSPB_DATA
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEMSIZE];

  logic [BE_WIDTH-1:0]   req_we   [2];
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_data [2];
  logic [DATA_WIDTH-1:0] rd_word  [2];
  logic [DATA_WIDTH-1:0] rsp_head [2];
  logic [DATA_WIDTH-1:0] rsp_data [2];
  logic [DATA_WIDTH-1:0] pd       [2][LATENCY];
  logic [DATA_WIDTH-1:0] fifo     [2][RESP_DEPTH];
  logic [LATENCY-1:0]    pv       [2];
  logic [PW-1:0]         rd_ptr   [2];
  logic [PW-1:0]         wr_ptr   [2];
  logic [CW-1:0]         cnt      [2];
  logic [CW-1:0]         credit   [2];

  logic [1:0] req_valid, req_ready, rsp_ready, rsp_valid, in_range;
  logic [1:0] rd_acc, wr_acc, fifo_empty, pop, push, fifo_pop;

  assign req_valid   = {REQB_VALID, REQA_VALID};
  assign rsp_ready   = {RSPB_READY, RSPA_READY};
  assign req_we[0]   = REQA_WE;
  assign req_we[1]   = REQB_WE;
  assign req_addr[0] = REQA_ADDR;
  assign req_addr[1] = REQB_ADDR;
  assign req_data[0] = REQA_DATA;
  assign req_data[1] = REQB_DATA;

  assign REQA_READY = req_ready[0];
  assign REQB_READY = req_ready[1];
  assign RSPA_VALID = rsp_valid[0];
  assign RSPB_VALID = rsp_valid[1];
  assign RSPA_DATA  = rsp_data[0];
  assign RSPB_DATA  = rsp_data[1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(RESP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // The last pipeline stage bypasses an empty FIFO so the response appears LATENCY cycles after acceptance.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_ready[p]  = RST_N && (credit[p] != '0);
      in_range[p]   = int'(req_addr[p]) < MEMSIZE;
      rd_acc[p]     = req_valid[p] && req_ready[p] && (req_we[p] == '0);
      wr_acc[p]     = req_valid[p] && req_ready[p] && (req_we[p] != '0) && in_range[p];
      rd_word[p]    = in_range[p] ? mem[req_addr[p]] : '0;
      fifo_empty[p] = (cnt[p] == '0);
      rsp_valid[p]  = !fifo_empty[p] || pv[p][LATENCY-1];
      rsp_head[p]   = fifo_empty[p] ? pd[p][LATENCY-1] : fifo[p][rd_ptr[p]];
      rsp_data[p]   = rsp_valid[p] ? rsp_head[p] : '0;
      pop[p]        = rsp_valid[p] && rsp_ready[p];
      push[p]       = pv[p][LATENCY-1] && !(fifo_empty[p] && rsp_ready[p]);
      fifo_pop[p]   = pop[p] && !fifo_empty[p];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int p = 0; p < 2; p++) begin
        pv[p]     <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        cnt[p]    <= '0;
        credit[p] <= CW'(RESP_DEPTH);
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pv[p] <= (pv[p] << 1) | LATENCY'(rd_acc[p]);
        if (push[p])     wr_ptr[p] <= ptr_inc(wr_ptr[p]);
        if (fifo_pop[p]) rd_ptr[p] <= ptr_inc(rd_ptr[p]);
        if (push[p] && !fifo_pop[p])      cnt[p] <= cnt[p] + 1'b1;
        else if (fifo_pop[p] && !push[p]) cnt[p] <= cnt[p] - 1'b1;
        if (rd_acc[p] && !pop[p])      credit[p] <= credit[p] - 1'b1;
        else if (pop[p] && !rd_acc[p]) credit[p] <= credit[p] + 1'b1;
      end
    end
  end

  // Port A's lane writes are issued last so they win a same-address, same-lane collision.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      pd[p][0] <= rd_word[p];
      for (int i = 1; i < LATENCY; i++) pd[p][i] <= pd[p][i-1];
      if (push[p]) fifo[p][wr_ptr[p]] <= pd[p][LATENCY-1];
    end
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (wr_acc[1] && req_we[1][b]) mem[req_addr[1]][8*b +: 8] <= req_data[1][8*b +: 8];
      if (wr_acc[0] && req_we[0][b]) mem[req_addr[0]][8*b +: 8] <= req_data[0][8*b +: 8];
    end
  end

endmodule
